// File: rtl/fm_seek_ctrl.sv
// FM tune/seek controller: retunes the NCO phase increment, discards settling samples,
// averages CORDIC magnitude and decides lock. Define FM_SEEK_RSSI_EN to register rssi.
module fm_seek_ctrl #(
    parameter int unsigned          PHI_WIDTH      = 32,
    parameter int unsigned          MAG_WIDTH      = 16,
    parameter int unsigned          AVG_LOG2       = 6,
    parameter int unsigned          SETTLE_SAMPLES = 256,
    parameter logic [PHI_WIDTH-1:0] RESET_PHI      = '0
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [PHI_WIDTH-1:0] cmd_phi,
    input  logic                 cmd_abort,
    input  logic [PHI_WIDTH-1:0] phi_step,
    input  logic [PHI_WIDTH-1:0] phi_lo,
    input  logic [PHI_WIDTH-1:0] phi_hi,
    input  logic [15:0]          scan_limit,
    input  logic [MAG_WIDTH-1:0] threshold,
    input  logic [MAG_WIDTH-1:0] mag_in,
    input  logic                 mag_valid,
    output logic [PHI_WIDTH-1:0] phi_inc,
    output logic                 busy,
    output logic                 locked,
    output logic                 mute,
    output logic [MAG_WIDTH-1:0] rssi
);

    localparam int unsigned SET_W  = $clog2(SETTLE_SAMPLES + 1);
    localparam int unsigned MCNT_W = AVG_LOG2 + 1;
    localparam int unsigned ACC_W  = MAG_WIDTH + AVG_LOG2;
    localparam int unsigned AVG_N  = 1 << AVG_LOG2;

    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_SAMPLES - 1);
    localparam logic [MCNT_W-1:0] MEAS_LAST   = MCNT_W'(AVG_N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_DECIDE,
        S_STEP
    } state_t;

    typedef enum logic [1:0] {
        OP_TUNE = 2'b00,
        OP_UP   = 2'b01,
        OP_DOWN = 2'b10,
        OP_RSVD = 2'b11
    } op_t;

    state_t               state_q, state_d;
    op_t                  op_q, op_d;
    logic [PHI_WIDTH-1:0] phi_q, phi_d;
    logic [PHI_WIDTH-1:0] start_phi_q, start_phi_d;
    logic [15:0]          step_cnt_q, step_cnt_d;
    logic [SET_W-1:0]     settle_cnt_q, settle_cnt_d;
    logic [MCNT_W-1:0]    meas_cnt_q, meas_cnt_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic                 locked_q, locked_d;

    logic                 abort;
    logic                 settle_done;
    logic                 meas_done;
    logic                 meas_locked;
    logic                 scan_done;
    logic [MAG_WIDTH-1:0] avg;
    logic [PHI_WIDTH-1:0] step_base;
    logic [PHI_WIDTH:0]   up_sum;
    logic [PHI_WIDTH:0]   lo_sum;
    logic [PHI_WIDTH-1:0] step_phi;

    assign abort       = cmd_abort && (state_q != S_IDLE);
    assign settle_done = mag_valid && (settle_cnt_q == SETTLE_LAST);
    assign meas_done   = mag_valid && (meas_cnt_q == MEAS_LAST);
    assign avg         = acc_q[ACC_W-1:AVG_LOG2];
    assign meas_locked = (avg >= threshold);
    // Compared with >= so a zero limit still stops after the mandatory first step.
    assign scan_done   = (step_cnt_q >= scan_limit);

    // The first step of a seek starts from the increment latched at acceptance.
    assign step_base = (step_cnt_q == 16'd0) ? start_phi_q : phi_q;
    assign up_sum    = {1'b0, step_base} + {1'b0, phi_step};
    assign lo_sum    = {1'b0, phi_lo} + {1'b0, phi_step};

    always_comb begin
        if (op_q == OP_DOWN) begin
            step_phi = ({1'b0, step_base} < lo_sum) ? phi_hi : (step_base - phi_step);
        end else begin
            step_phi = (up_sum > {1'b0, phi_hi}) ? phi_lo : up_sum[PHI_WIDTH-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (op_t'(cmd_op) == OP_TUNE) begin
                        state_d = S_SETTLE;
                    end else if (op_t'(cmd_op) == OP_UP || op_t'(cmd_op) == OP_DOWN) begin
                        state_d = S_STEP;
                    end
                end
            end
            S_STEP:    state_d = S_SETTLE;
            S_SETTLE:  if (settle_done) state_d = S_MEASURE;
            S_MEASURE: if (meas_done) state_d = S_DECIDE;
            S_DECIDE: begin
                if (op_q == OP_TUNE || meas_locked || scan_done) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_STEP;
                end
            end
            default:   state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        mute      = (state_q != S_IDLE) || !locked_q;
    end

    always_comb begin
        op_d         = op_q;
        phi_d        = phi_q;
        start_phi_d  = start_phi_q;
        step_cnt_d   = step_cnt_q;
        settle_cnt_d = settle_cnt_q;
        meas_cnt_d   = meas_cnt_q;
        acc_d        = acc_q;
        locked_d     = locked_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    locked_d = 1'b0;
                    if (op_t'(cmd_op) == OP_TUNE) begin
                        op_d  = OP_TUNE;
                        phi_d = cmd_phi;
                    end else if (op_t'(cmd_op) == OP_UP || op_t'(cmd_op) == OP_DOWN) begin
                        op_d        = op_t'(cmd_op);
                        start_phi_d = phi_q;
                        step_cnt_d  = 16'd0;
                    end
                end
            end
            S_STEP: begin
                phi_d      = step_phi;
                step_cnt_d = step_cnt_q + 16'd1;
            end
            S_SETTLE: begin
                if (mag_valid) begin
                    settle_cnt_d = settle_done ? '0 : settle_cnt_q + 1'b1;
                end
            end
            S_MEASURE: begin
                if (mag_valid) begin
                    acc_d      = acc_q + ACC_W'(mag_in);
                    meas_cnt_d = meas_done ? '0 : meas_cnt_q + 1'b1;
                end
            end
            S_DECIDE: begin
                locked_d = meas_locked;
                acc_d    = '0;
            end
            default: ;
        endcase
        // Abort outranks any coincident sample; the increment stays where it is.
        if (abort) begin
            phi_d        = phi_q;
            locked_d     = 1'b0;
            step_cnt_d   = '0;
            settle_cnt_d = '0;
            meas_cnt_d   = '0;
            acc_d        = '0;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            op_q         <= OP_TUNE;
            phi_q        <= RESET_PHI;
            start_phi_q  <= RESET_PHI;
            step_cnt_q   <= '0;
            settle_cnt_q <= '0;
            meas_cnt_q   <= '0;
            acc_q        <= '0;
            locked_q     <= 1'b0;
        end else begin
            op_q         <= op_d;
            phi_q        <= phi_d;
            start_phi_q  <= start_phi_d;
            step_cnt_q   <= step_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            meas_cnt_q   <= meas_cnt_d;
            acc_q        <= acc_d;
            locked_q     <= locked_d;
        end
    end

    assign phi_inc = phi_q;
    assign locked  = locked_q;

`ifdef FM_SEEK_RSSI_EN
    logic [MAG_WIDTH-1:0] rssi_q, rssi_d;

    always_comb begin
        rssi_d = (state_q == S_DECIDE) ? avg : rssi_q;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            rssi_q <= '0;
        end else begin
            rssi_q <= rssi_d;
        end
    end

    assign rssi = rssi_q;
`else
    assign rssi = '0;
`endif

endmodule

// File: tb/tb_fm_seek_ctrl.sv
// Scoreboard bench for fm_seek_ctrl: expected phi_inc changes and operation
// completions are queued by the stimulus and checked by an independent monitor.
module tb_fm_seek_ctrl;

    logic        clk;
    logic        areset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_phi;
    logic        cmd_abort;
    logic [31:0] phi_step;
    logic [31:0] phi_lo;
    logic [31:0] phi_hi;
    logic [15:0] scan_limit;
    logic [15:0] threshold;
    logic [15:0] mag_in;
    logic        mag_valid;
    logic [31:0] phi_inc;
    logic        busy;
    logic        locked;
    logic        mute;
    logic [15:0] rssi;

    fm_seek_ctrl dut (
        .clk        (clk),
        .areset     (areset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_phi    (cmd_phi),
        .cmd_abort  (cmd_abort),
        .phi_step   (phi_step),
        .phi_lo     (phi_lo),
        .phi_hi     (phi_hi),
        .scan_limit (scan_limit),
        .threshold  (threshold),
        .mag_in     (mag_in),
        .mag_valid  (mag_valid),
        .phi_inc    (phi_inc),
        .busy       (busy),
        .locked     (locked),
        .mute       (mute),
        .rssi       (rssi)
    );

    typedef struct {
        string       name;
        logic [31:0] phi;
        logic        locked;
        logic [15:0] rssi;
    } done_t;

    logic [31:0] exp_phi_q[$];
    done_t       exp_done_q[$];

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] sig_phi  = 32'd0;
    logic [31:0] model_phi;
    int          npulse;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_rssi(input logic [15:0] avg);
`ifdef FM_SEEK_RSSI_EN
        return avg;
`else
        return 16'd0 & avg;
`endif
    endfunction

    function automatic logic [15:0] mag_of(input logic [31:0] p);
        return (p == sig_phi) ? 16'd1000 : 16'd10;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        mag_in    = mag_of(phi_inc);
        mag_valid = 1'b1;
        tick();
        mag_valid = 1'b0;
        tick();
    endtask

    task automatic expect_phi(input logic [31:0] p);
        if (p != model_phi) exp_phi_q.push_back(p);
        model_phi = p;
    endtask

    task automatic expect_done(input string nm, input logic lk, input logic [15:0] avg);
        done_t d;
        d.name   = nm;
        d.phi    = model_phi;
        d.locked = lk;
        d.rssi   = exp_rssi(avg);
        exp_done_q.push_back(d);
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] p, input string nm);
        check({nm, " ready"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_phi   = p;
        tick();
        cmd_valid = 1'b0;
        check({nm, " busy"}, busy, 1);
        check({nm, " locked clr"}, locked, 0);
        if (op == 2'b00) check({nm, " phi N+1"}, phi_inc, p);
    endtask

    task automatic run_idle(input string nm, output int n);
        n = 0;
        while (busy && n < 3000) begin
            pulse();
            n++;
        end
        check({nm, " finished"}, busy, 0);
    endtask

    // Monitor: every phi_inc change and every busy fall is matched against the queues.
    initial begin
        logic [31:0] prev_phi;
        logic        prev_busy;
        done_t       d;
        prev_phi  = 32'd0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (areset) begin
                prev_phi  = phi_inc;
                prev_busy = busy;
            end else begin
                if (phi_inc !== prev_phi) begin
                    if (exp_phi_q.size() == 0) check("unexpected phi change", phi_inc, prev_phi);
                    else check("phi sequence", phi_inc, exp_phi_q.pop_front());
                    prev_phi = phi_inc;
                end
                if (prev_busy && !busy) begin
                    if (exp_done_q.size() == 0) begin
                        check("unexpected completion", busy, 1);
                    end else begin
                        d = exp_done_q.pop_front();
                        check({d.name, " done phi"}, phi_inc, d.phi);
                        check({d.name, " done locked"}, locked, d.locked);
                        check({d.name, " done mute"}, mute, !d.locked);
                        check({d.name, " done rssi"}, rssi, d.rssi);
                    end
                end
                prev_busy = busy;
            end
        end
    end

    initial begin
        areset     = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = 2'b00;
        cmd_phi    = 32'd0;
        cmd_abort  = 1'b0;
        phi_step   = 32'd100;
        phi_lo     = 32'd1000;
        phi_hi     = 32'd1300;
        scan_limit = 16'd10;
        threshold  = 16'd500;
        mag_in     = 16'd0;
        mag_valid  = 1'b0;
        model_phi  = 32'd0;
        repeat (3) tick();
        check("reset phi", phi_inc, 0);
        check("reset busy", busy, 0);
        check("reset ready", cmd_ready, 1);
        check("reset mute", mute, 1);
        check("reset locked", locked, 0);
        check("reset rssi", rssi, 0);
        areset = 1'b0;
        tick();

        // Tune with strong signal: 256 settle + 64 measure pulses.
        sig_phi = 32'd212550939;
        expect_phi(32'd212550939);
        expect_done("tune", 1'b1, 16'd1000);
        issue(2'b00, 32'd212550939, "tune");
        run_idle("tune", npulse);
        check("tune pulse count", npulse, 320);
        check("tune locked", locked, 1);
        check("tune mute", mute, 0);

        // Abort while idle does nothing.
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        check("idle abort locked", locked, 1);
        check("idle abort phi", phi_inc, 212550939);

        // Seek up finds the station at 1200.
        sig_phi = 32'd1200;
        expect_phi(32'd1000);
        expect_done("tune1000", 1'b0, 16'd10);
        issue(2'b00, 32'd1000, "tune1000");
        run_idle("tune1000", npulse);
        expect_phi(32'd1100);
        expect_phi(32'd1200);
        expect_done("seek up", 1'b1, 16'd1000);
        issue(2'b01, 32'd0, "seek up");
        run_idle("seek up", npulse);

        // Seek up with no signal wraps and gives up after 4 steps.
        sig_phi    = 32'd0;
        scan_limit = 16'd4;
        expect_phi(32'd1300);
        expect_done("tune1300", 1'b0, 16'd10);
        issue(2'b00, 32'd1300, "tune1300");
        run_idle("tune1300", npulse);
        expect_phi(32'd1000);
        expect_phi(32'd1100);
        expect_phi(32'd1200);
        expect_phi(32'd1300);
        expect_done("seek wrap", 1'b0, 16'd10);
        issue(2'b01, 32'd0, "seek wrap");
        run_idle("seek wrap", npulse);
        check("seek wrap mute", mute, 1);

        // Seek down from the band bottom wraps; zero limit means exactly one step.
        scan_limit = 16'd0;
        expect_phi(32'd1000);
        expect_done("tune1000b", 1'b0, 16'd10);
        issue(2'b00, 32'd1000, "tune1000b");
        run_idle("tune1000b", npulse);
        expect_phi(32'd1300);
        expect_done("seek down wrap", 1'b0, 16'd10);
        issue(2'b10, 32'd0, "seek down wrap");
        run_idle("seek down wrap", npulse);

        // Plain seek down locks on 1100.
        sig_phi    = 32'd1100;
        scan_limit = 16'd5;
        expect_phi(32'd1200);
        expect_phi(32'd1100);
        expect_done("seek down", 1'b1, 16'd1000);
        issue(2'b10, 32'd0, "seek down");
        run_idle("seek down", npulse);

        // Abort during MEASURE, coincident with a sample; ignored command while busy.
        sig_phi = 32'd1234;
        expect_phi(32'd1234);
        issue(2'b00, 32'd1234, "abort tune");
        repeat (266) pulse();
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_phi   = 32'd999;
        tick();
        check("busy ready", cmd_ready, 0);
        tick();
        cmd_valid = 1'b0;
        check("ignored cmd busy", busy, 1);
        expect_done("abort", 1'b0, 16'd1000);
        mag_in    = 16'd1000;
        mag_valid = 1'b1;
        cmd_abort = 1'b1;
        tick();
        mag_valid = 1'b0;
        cmd_abort = 1'b0;
        check("abort busy", busy, 0);
        check("abort phi", phi_inc, 1234);
        check("abort locked", locked, 0);
        check("abort ready", cmd_ready, 1);
        expect_done("after abort", 1'b1, 16'd1000);
        issue(2'b00, 32'd1234, "after abort");
        run_idle("after abort", npulse);
        check("after abort pulse count", npulse, 320);

        // Asynchronous reset mid-SETTLE.
        sig_phi = 32'd0;
        expect_phi(32'd4321);
        issue(2'b00, 32'd4321, "reset tune");
        repeat (100) pulse();
        #2;
        areset = 1'b1;
        #1;
        check("async reset phi", phi_inc, 0);
        check("async reset ready", cmd_ready, 1);
        check("async reset busy", busy, 0);
        check("async reset rssi", rssi, 0);
        #3;
        areset    = 1'b0;
        model_phi = 32'd0;
        tick();
        sig_phi = 32'd500;
        expect_phi(32'd500);
        expect_done("post reset", 1'b1, 16'd1000);
        issue(2'b00, 32'd500, "post reset");
        run_idle("post reset", npulse);
        check("post reset pulse count", npulse, 320);

        repeat (4) tick();
        check("phi queue drained", exp_phi_q.size(), 0);
        check("done queue drained", exp_done_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
